// File: rtl/ps2_scancode_decoder.sv
// Scan Code Set 2 byte-stream decoder: prefix FSM, shift tracking, US ASCII translation
// and a first-word fall-through event FIFO with sticky overflow.
module ps2_scancode_decoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_data,
  input  logic       event_ready,
  output logic       event_valid,
  output logic [7:0] event_code,
  output logic       event_extended,
  output logic       event_release,
  output logic [7:0] event_ascii,
  output logic       shift_active,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       extended;
    logic       brk;
    logic [7:0] ascii;
  } event_t;

  function automatic logic [7:0] ascii_lut(input logic [7:0] code, input logic shift);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = shift ? "A" : "a";
      8'h32: a = shift ? "B" : "b";
      8'h21: a = shift ? "C" : "c";
      8'h23: a = shift ? "D" : "d";
      8'h24: a = shift ? "E" : "e";
      8'h2B: a = shift ? "F" : "f";
      8'h34: a = shift ? "G" : "g";
      8'h33: a = shift ? "H" : "h";
      8'h43: a = shift ? "I" : "i";
      8'h3B: a = shift ? "J" : "j";
      8'h42: a = shift ? "K" : "k";
      8'h4B: a = shift ? "L" : "l";
      8'h3A: a = shift ? "M" : "m";
      8'h31: a = shift ? "N" : "n";
      8'h44: a = shift ? "O" : "o";
      8'h4D: a = shift ? "P" : "p";
      8'h15: a = shift ? "Q" : "q";
      8'h2D: a = shift ? "R" : "r";
      8'h1B: a = shift ? "S" : "s";
      8'h2C: a = shift ? "T" : "t";
      8'h3C: a = shift ? "U" : "u";
      8'h2A: a = shift ? "V" : "v";
      8'h1D: a = shift ? "W" : "w";
      8'h22: a = shift ? "X" : "x";
      8'h35: a = shift ? "Y" : "y";
      8'h1A: a = shift ? "Z" : "z";
      8'h45: a = shift ? ")" : "0";
      8'h16: a = shift ? "!" : "1";
      8'h1E: a = shift ? "@" : "2";
      8'h26: a = shift ? "#" : "3";
      8'h25: a = shift ? "$" : "4";
      8'h2E: a = shift ? "%" : "5";
      8'h36: a = shift ? "^" : "6";
      8'h3D: a = shift ? "&" : "7";
      8'h3E: a = shift ? "*" : "8";
      8'h46: a = shift ? "(" : "9";
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      8'h66: a = 8'h08;
      8'h0D: a = 8'h09;
      8'h76: a = 8'h1B;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  state_e      state_q, state_d;
  logic        l_shift_q, l_shift_d;
  logic        r_shift_q, r_shift_d;
  logic        overflow_q;
  logic [AW:0] wptr_q, rptr_q;
  event_t      mem [FIFO_DEPTH];

  logic        emit, emit_ext, emit_brk, discard;
  logic        empty, full, pop, push;
  event_t      new_ev, head;

  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_ext  = 1'b0;
    emit_brk  = 1'b0;
    l_shift_d = l_shift_q;
    r_shift_d = r_shift_q;
    // Link-level bytes from the keyboard that never form part of a key sequence in IDLE.
    discard   = (key_data == 8'hFA) || (key_data == 8'hAA) || (key_data == 8'hEE) ||
                (key_data == 8'hFE) || (key_data == 8'h00) || (key_data == 8'hFF);
    if (key_valid) begin
      case (state_q)
        StIdle: begin
          if (key_data == 8'hE0)      state_d = StExt;
          else if (key_data == 8'hF0) state_d = StBrk;
          else if (!discard)          emit = 1'b1;
        end
        StExt: begin
          if (key_data == 8'hF0)      state_d = StExtBrk;
          else if (key_data != 8'hE0) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = StIdle;
          end
        end
        StBrk: begin
          if (key_data == 8'hE0)      state_d = StExtBrk;
          else if (key_data != 8'hF0) begin
            emit     = 1'b1;
            emit_brk = 1'b1;
            state_d  = StIdle;
          end
        end
        default: begin
          if ((key_data != 8'hE0) && (key_data != 8'hF0)) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_brk = 1'b1;
            state_d  = StIdle;
          end
        end
      endcase
    end
    if (emit && !emit_ext) begin
      if (key_data == 8'h12) l_shift_d = !emit_brk;
      if (key_data == 8'h59) r_shift_d = !emit_brk;
    end
    new_ev.code     = key_data;
    new_ev.extended = emit_ext;
    new_ev.brk      = emit_brk;
    new_ev.ascii    = (emit_ext || emit_brk) ? 8'h00 :
                      ascii_lut(key_data, l_shift_q | r_shift_q);
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = !empty && event_ready;
  // When full, a same-cycle pop frees the head slot, which is exactly where wptr points.
  assign push  = emit && (!full || pop);
  assign head  = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      l_shift_q  <= 1'b0;
      r_shift_q  <= 1'b0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      l_shift_q <= l_shift_d;
      r_shift_q <= r_shift_d;
      if (emit && !push) overflow_q <= 1'b1;
      if (push)          wptr_q     <= wptr_q + PtrOne;
      if (pop)           rptr_q     <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wptr_q[AW-1:0]] <= new_ev;
  end

  always_comb begin
    event_valid    = !empty;
    event_code     = empty ? 8'h00 : head.code;
    event_extended = !empty && head.extended;
    event_release  = !empty && head.brk;
    event_ascii    = empty ? 8'h00 : head.ascii;
    shift_active   = l_shift_q | r_shift_q;
    overflow       = overflow_q;
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench: constant vector table, directed corner sequences and random byte
// streams compared against a prefix-flag / queue reference model.
module tb_ps2_scancode_decoder;

  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       event_ready = 1'b0;
  logic       event_valid;
  logic [7:0] event_code;
  logic       event_extended;
  logic       event_release;
  logic [7:0] event_ascii;
  logic       shift_active;
  logic       overflow;

  ps2_scancode_decoder #(.FIFO_DEPTH(Depth)) dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid      (key_valid),
    .key_data       (key_data),
    .event_ready    (event_ready),
    .event_valid    (event_valid),
    .event_code     (event_code),
    .event_extended (event_extended),
    .event_release  (event_release),
    .event_ascii    (event_ascii),
    .shift_active   (shift_active),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic [7:0] ascii;
  } ev_t;

  typedef struct {
    bit         sh;
    logic [7:0] code;
    logic [7:0] ascii;
  } vec_t;

  int checks = 0;
  int errors = 0;

  ev_t  mq[$];
  bit   m_pend_ext, m_pend_brk, m_lsh, m_rsh, m_ovf;
  logic [7:0] letter_codes [26];
  logic [7:0] digit_codes  [10];
  logic [7:0] digit_shift  [10];
  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_ascii(input logic [7:0] code, input bit sh);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == code) return sh ? 8'h41 + 8'(i) : 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == code) return sh ? digit_shift[i] : 8'h30 + 8'(i);
    case (code)
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      8'h0D: return 8'h09;
      8'h76: return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic kv, input logic [7:0] kd, input logic rdy);
    ev_t e;
    bit  do_emit;
    if (r) begin
      mq.delete();
      m_pend_ext = 0; m_pend_brk = 0; m_lsh = 0; m_rsh = 0; m_ovf = 0;
      return;
    end
    do_emit = 0;
    if (kv) begin
      if (kd == 8'hE0) m_pend_ext = 1;
      else if (kd == 8'hF0) m_pend_brk = 1;
      else if (!m_pend_ext && !m_pend_brk &&
               (kd inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) do_emit = 0;
      else begin
        do_emit = 1;
        e.code = kd; e.ext = m_pend_ext; e.rel = m_pend_brk;
        e.ascii = (m_pend_ext || m_pend_brk) ? 8'h00 : model_ascii(kd, m_lsh | m_rsh);
      end
    end
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (do_emit) begin
      if (mq.size() < Depth) mq.push_back(e);
      else m_ovf = 1;
      if (!e.ext && kd == 8'h12) m_lsh = !e.rel;
      if (!e.ext && kd == 8'h59) m_rsh = !e.rel;
      m_pend_ext = 0; m_pend_brk = 0;
    end
  endtask

  task automatic compare_all();
    check("valid", event_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("code",  event_code,     mq[0].code);
      check("ext",   event_extended, mq[0].ext);
      check("rel",   event_release,  mq[0].rel);
      check("ascii", event_ascii,    mq[0].ascii);
    end
    check("shift", shift_active, m_lsh | m_rsh);
    check("ovf",   overflow,     m_ovf);
  endtask

  task automatic cycle(input logic r, input logic kv, input logic [7:0] kd, input logic rdy);
    rst = r; key_valid = kv; key_data = kd; event_ready = rdy;
    @(posedge clk);
    #1;
    model_step(r, kv, kd, rdy);
    compare_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && mq.size() > 0; i++) cycle(0, 0, 8'h00, 1);
    check("drain_done", event_valid, 0);
  endtask

  initial begin
    letter_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                     8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                     8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    digit_codes  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    digit_shift  = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};
    tbl = '{'{0, 8'h1C, 8'h61}, '{1, 8'h1C, 8'h41}, '{0, 8'h1A, 8'h7A}, '{1, 8'h1A, 8'h5A},
            '{0, 8'h45, 8'h30}, '{1, 8'h45, 8'h29}, '{1, 8'h1E, 8'h40}, '{0, 8'h46, 8'h39},
            '{1, 8'h36, 8'h5E}, '{1, 8'h29, 8'h20}, '{0, 8'h5A, 8'h0D}, '{1, 8'h66, 8'h08},
            '{0, 8'h0D, 8'h09}, '{0, 8'h76, 8'h1B}, '{0, 8'h7E, 8'h00}};

    // Reset with a stray byte that must be ignored.
    cycle(1, 1, 8'h1C, 0);
    check("rst_code", event_code, 8'h00);
    check("rst_ascii", event_ascii, 8'h00);
    check("rst_ext", event_extended, 0);
    check("rst_rel", event_release, 0);

    // Single make and pop.
    cycle(0, 1, 8'h1C, 0);
    check("a_valid", event_valid, 1);
    check("a_ascii", event_ascii, 8'h61);
    cycle(0, 0, 8'h00, 1);
    check("a_popped", event_valid, 0);

    // Shift sequence, collected without popping.
    cycle(0, 1, 8'h12, 0);
    check("sh_on", shift_active, 1);
    cycle(0, 1, 8'h1C, 0);
    cycle(0, 1, 8'hF0, 0);
    cycle(0, 1, 8'h1C, 0);
    check("sh_full", event_valid, 1);
    cycle(0, 1, 8'hF0, 1);
    check("sh_held", shift_active, 1);
    check("sh_2nd_ascii", event_ascii, 8'h41);
    cycle(0, 1, 8'h12, 1);
    check("sh_off", shift_active, 0);
    drain();

    // Extended make/break with interleaved link bytes.
    cycle(0, 1, 8'hFA, 0);
    cycle(0, 1, 8'hE0, 0);
    cycle(0, 1, 8'h75, 0);
    cycle(0, 1, 8'hAA, 0);
    cycle(0, 1, 8'hE0, 0);
    cycle(0, 1, 8'hF0, 0);
    cycle(0, 1, 8'h75, 0);
    check("ext_mk_ext", event_extended, 1);
    check("ext_mk_rel", event_release, 0);
    cycle(0, 0, 8'h00, 1);
    check("ext_br_rel", event_release, 1);
    check("ext_br_ext", event_extended, 1);
    drain();

    // Translation table.
    foreach (tbl[i]) begin
      if (tbl[i].sh) cycle(0, 1, 8'h12, 1);
      drain();
      cycle(0, 1, tbl[i].code, 0);
      check("tbl_code", event_code, tbl[i].code);
      check("tbl_ascii", event_ascii, tbl[i].ascii);
      cycle(0, 0, 8'h00, 1);
      if (tbl[i].sh) begin
        cycle(0, 1, 8'hF0, 1);
        cycle(0, 1, 8'h12, 1);
      end
      drain();
    end

    // Overflow, then push+pop while full, then ordered drain.
    for (int i = 0; i < Depth + 2; i++) cycle(0, 1, 8'h16, 0);
    check("ovf_set", overflow, 1);
    cycle(0, 1, 8'h1E, 1);
    for (int i = 0; i < Depth; i++) begin
      check("ovf_order", event_code, (i < Depth - 1) ? 8'h16 : 8'h1E);
      cycle(0, 0, 8'h00, 1);
    end
    check("ovf_empty", event_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Reset in the middle of E0 F0 with shift held.
    cycle(0, 1, 8'h59, 1);
    drain();
    cycle(0, 1, 8'hE0, 0);
    cycle(0, 1, 8'hF0, 0);
    cycle(1, 0, 8'h00, 0);
    check("r2_shift", shift_active, 0);
    check("r2_ovf", overflow, 0);
    cycle(0, 1, 8'h29, 0);
    check("r2_code", event_code, 8'h29);
    check("r2_ext", event_extended, 0);
    check("r2_rel", event_release, 0);
    check("r2_ascii", event_ascii, 8'h20);
    drain();

    // Random byte stream.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] b;
      case ($urandom_range(0, 11))
        0: b = 8'hE0;  1: b = 8'hF0;  2: b = 8'hFA;  3: b = 8'hAA;
        4: b = 8'h12;  5: b = 8'h59;  6: b = 8'h1C;  7: b = 8'h16;
        8: b = 8'h45;  9: b = 8'h29;  10: b = 8'h00;
        default: b = 8'($urandom);
      endcase
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1, b,
            $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
